// File: rtl/timer_seq_ctrl.sv
// -----------------------------------------------------------------------------
// timer_seq_ctrl
//
// Sequencer for an external loadable up-counter. A sequence loads the counter
// with a captured start value, lets it count up (wrapping through max -> 0)
// until it reaches the captured end value, then signals one completed period.
// In periodic mode the load/count/done cycle repeats until stop is asserted.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous reset, active low
//   start      : begin a sequence (only honoured while idle)
//   stop       : abort the current sequence (honoured in every state)
//   periodic   : 0 = one-shot, 1 = auto-reload (captured with start)
//   start_val  : initial count (captured with start)
//   end_val    : terminal count (captured with start)
//   cnt_q      : present value of the external counter
//   cnt_en     : count enable to the external counter
//   cnt_ld     : synchronous load strobe to the external counter
//   cnt_data   : load value for the external counter
//   busy       : high whenever a sequence is in progress
//   done       : one-cycle pulse per completed period
//   aborted    : one-cycle pulse after stop ends a sequence
//   periods    : completed periods since the last accepted start
// -----------------------------------------------------------------------------
module timer_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_ld,
    output logic [WIDTH-1:0] cnt_data,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] periods
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Sequence configuration, frozen for the lifetime of a sequence.
    typedef struct packed {
        logic [WIDTH-1:0] start_v;
        logic [WIDTH-1:0] end_v;
        logic             periodic;
    } cfg_t;

    state_t state;
    state_t state_nxt;
    cfg_t   cfg;
    logic   accept;
    logic   at_end;
    logic   abort_evt;

    // A new sequence is accepted only from IDLE and never when stop is also high.
    assign accept    = (state == IDLE) && start && !stop;
    assign at_end    = (cnt_q == cfg.end_v);
    assign abort_evt = (state != IDLE) && stop;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop)        state_nxt = IDLE;
                else if (at_end) state_nxt = DONE;
            end
            DONE: begin
                if (stop)              state_nxt = IDLE;
                else if (cfg.periodic) state_nxt = LOAD;
                else                   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore decodes. cnt_en drops as soon as the counter shows the end value,
    // so the counter parks on it while the FSM moves to DONE. With a zero
    // distance this keeps cnt_en low for the whole single RUN cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_en = 1'b0;
        cnt_ld = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        unique case (state)
            IDLE: busy   = 1'b0;
            LOAD: cnt_ld = 1'b1;
            RUN:  cnt_en = !at_end;
            DONE: done   = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign cnt_data = cfg.start_v;

    // -------------------------------------------------------------------------
    // Captured configuration. Only written on an accepted start, so a start
    // pulse mid-sequence cannot disturb it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg <= '0;
        end else if (accept) begin
            cfg.start_v  <= start_val;
            cfg.end_v    <= end_val;
            cfg.periodic <= periodic;
        end
    end

    // -------------------------------------------------------------------------
    // Period counter. The DONE-state increment is unconditional so a stop
    // arriving in DONE still counts that period.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            periods <= '0;
        end else if (accept) begin
            periods <= '0;
        end else if (state == DONE) begin
            periods <= periods + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Abort pulse: registered so it appears in the cycle after the stop edge,
    // when the FSM is already back in IDLE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort_evt;
        end
    end

endmodule
